// File: rtl/twi_slave_logic.sv
// twi_slave_logic: TWI (I2C) responder. Oversamples SCL/SDA on the PLB clock,
// detects START/STOP, answers one 7-bit address, delivers written bytes on a
// strobe port and serves read bytes from a data port. No clock stretching.
module twi_slave_logic #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       iPlbClk,
  input  logic       iPlbReset,
  input  logic       iScl,
  input  logic       iSda,
  output logic       oSda,
  input  logic [7:0] iTxData,
  output logic       oTxTaken,
  output logic [7:0] oRxData,
  output logic       oRxValid,
  output logic       oBusy,
  output logic       oDir
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    TX,
    TX_ACK
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_hist;
  logic                   sda_hist;
  logic                   scl_now;
  logic                   sda_now;
  logic                   scl_rise;
  logic                   scl_fall;
  logic                   start_cond;
  logic                   stop_cond;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [6:0] tx_shift;
  logic       ack_low;
  logic       ack_ok;

  // Synchronize both bus lines and keep one history flop for edge detection;
  // all flops preset to 1 so an idle (released) bus looks quiet after reset.
  always_ff @(posedge iPlbClk) begin
    if (iPlbReset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], iScl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], iSda};
      scl_hist <= scl_sync[SYNC_STAGES-1];
      sda_hist <= sda_sync[SYNC_STAGES-1];
    end
  end

  // Single-cycle bus events derived from the synchronized levels.
  always_comb begin
    scl_now    = scl_sync[SYNC_STAGES-1];
    sda_now    = sda_sync[SYNC_STAGES-1];
    scl_rise   = scl_now & ~scl_hist;
    scl_fall   = ~scl_now & scl_hist;
    start_cond = scl_now & sda_hist & ~sda_now;
    stop_cond  = scl_now & ~sda_hist & sda_now;
  end

  // Protocol FSM: STOP/START override everything, otherwise bits are sampled
  // on SCL rise and SDA is only ever changed on SCL fall.
  always_ff @(posedge iPlbClk) begin
    if (iPlbReset) begin
      state    <= IDLE;
      oSda     <= 1'b1;
      oTxTaken <= 1'b0;
      oRxValid <= 1'b0;
      oRxData  <= 8'h00;
      oDir     <= 1'b0;
      bit_cnt  <= 3'd0;
      shift    <= 7'h00;
      tx_shift <= 7'h00;
      ack_low  <= 1'b0;
      ack_ok   <= 1'b0;
    end else begin
      oTxTaken <= 1'b0;
      oRxValid <= 1'b0;
      if (stop_cond) begin
        state   <= IDLE;
        oSda    <= 1'b1;
        bit_cnt <= 3'd0;
      end else if (start_cond) begin
        state   <= ADDR;
        oSda    <= 1'b1;
        bit_cnt <= 3'd0;
      end else begin
        case (state)
          IDLE: begin
            oSda <= 1'b1;
          end
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_now};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift == SLAVE_ADDR) begin
                  state   <= ADDR_ACK;
                  oDir    <= sda_now;
                  ack_low <= 1'b0;
                end else begin
                  state <= IDLE;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!ack_low) begin
                oSda    <= 1'b0;
                ack_low <= 1'b1;
              end else begin
                ack_low <= 1'b0;
                if (oDir) begin
                  state    <= TX;
                  tx_shift <= iTxData[6:0];
                  oTxTaken <= 1'b1;
                  oSda     <= iTxData[7];
                end else begin
                  state <= RX;
                  oSda  <= 1'b1;
                end
              end
            end
          end
          RX: begin
            if (scl_rise) begin
              shift   <= {shift[5:0], sda_now};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                oRxData  <= {shift, sda_now};
                oRxValid <= 1'b1;
                state    <= RX_ACK;
                ack_low  <= 1'b0;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              if (!ack_low) begin
                oSda    <= 1'b0;
                ack_low <= 1'b1;
              end else begin
                ack_low <= 1'b0;
                oSda    <= 1'b1;
                state   <= RX;
              end
            end
          end
          TX: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                oSda   <= 1'b1;
                state  <= TX_ACK;
                ack_ok <= 1'b0;
              end else begin
                oSda     <= tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
              end
            end
          end
          TX_ACK: begin
            if (scl_rise) begin
              if (sda_now) begin
                state <= IDLE;
                oSda  <= 1'b1;
              end else begin
                ack_ok <= 1'b1;
              end
            end else if (scl_fall && ack_ok) begin
              ack_ok   <= 1'b0;
              tx_shift <= iTxData[6:0];
              oTxTaken <= 1'b1;
              oSda     <= iTxData[7];
              state    <= TX;
            end
          end
          default: begin
            state <= IDLE;
            oSda  <= 1'b1;
          end
        endcase
      end
    end
  end

  // Busy whenever this responder has been addressed and not yet released.
  always_comb begin
    oBusy = (state == ADDR_ACK) || (state == RX) || (state == RX_ACK) ||
            (state == TX) || (state == TX_ACK);
  end

endmodule

// File: tb/tb_twi_slave_logic.sv
// tb_twi_slave_logic: drives a behavioural TWI master against the responder,
// with an open-drain SDA model, and checks results through a scoreboard.
module tb_twi_slave_logic;

  localparam logic [6:0] SLAVE = 7'h50;
  localparam int         H     = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_scl;
  logic       m_sda;
  logic       bus_sda;
  logic       sda_drv;
  logic [7:0] tx_data;
  logic       tx_taken;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       dir;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_plan[$];
  logic [7:0] payload[$];
  int         tx_idx    = 0;
  int         taken_cnt = 0;

  assign bus_sda = m_sda & sda_drv;

  twi_slave_logic #(.SLAVE_ADDR(SLAVE), .SYNC_STAGES(2)) dut (
    .iPlbClk  (clk),
    .iPlbReset(reset),
    .iScl     (m_scl),
    .iSda     (bus_sda),
    .oSda     (sda_drv),
    .iTxData  (tx_data),
    .oTxTaken (tx_taken),
    .oRxData  (rx_data),
    .oRxValid (rx_valid),
    .oBusy    (busy),
    .oDir     (dir)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expected received bytes on each strobe and serves read data.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (rx_valid) begin
        if (rx_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL rx_strobe: got unexpected byte 0x%02h expected none", rx_data);
        end else begin
          check("rx_data", rx_data, rx_q.pop_front());
        end
      end
      if (tx_taken) begin
        taken_cnt++;
        tx_idx++;
      end
    end
    tx_data = (tx_idx < tx_plan.size()) ? tx_plan[tx_idx] : 8'hFF;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; cyc(H);
    m_scl = 1'b1; cyc(H);
    m_sda = 1'b0; cyc(H);
    m_scl = 1'b0; cyc(H);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; cyc(H);
    m_scl = 1'b1; cyc(H);
    m_sda = 1'b1; cyc(H);
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    m_sda = b; cyc(H);
    m_scl = 1'b1; cyc(H);
    seen  = bus_sda;
    m_scl = 1'b0; cyc(2);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic do_ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~do_ack, s);
  endtask

  // One master transaction; expectations come from the addressing rules alone.
  task automatic applyStimulus(input logic [6:0] addr, input logic rd, input int n, input bit rep);
    logic       ack;
    logic [7:0] got;
    bit         hit;
    int         taken0;
    hit    = (addr == SLAVE);
    taken0 = taken_cnt;
    if (hit && rd) for (int i = 0; i < n; i++) tx_plan.push_back(payload[i]);
    bus_start();
    write_byte({addr, rd}, ack);
    check("addr_ack", ack, hit ? 1'b0 : 1'b1);
    check("busy_addr", busy, hit);
    if (hit) begin
      check("dir", dir, rd);
      for (int i = 0; i < n; i++) begin
        if (!rd) begin
          rx_q.push_back(payload[i]);
          write_byte(payload[i], ack);
          check("data_ack", ack, 1'b0);
        end else begin
          read_byte(i < n - 1, got);
          check("rd_byte", got, payload[i]);
        end
      end
      if (rd) begin
        check("busy_nack", busy, 1'b0);
        check("sda_nack", sda_drv, 1'b1);
      end
    end
    if (!rep) begin
      bus_stop();
      cyc(H);
      check("busy_stop", busy, 1'b0);
    end
    check("rx_pending", rx_q.size(), 0);
    check("taken_cnt", taken_cnt - taken0, (hit && rd) ? n : 0);
  endtask

  task automatic checkOutput();
    check("rst_sda", sda_drv, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rxdata", rx_data, 8'h00);
    check("rst_rxvalid", rx_valid, 1'b0);
    check("rst_taken", tx_taken, 1'b0);
    check("rst_dir", dir, 1'b0);
  endtask

  initial begin
    logic s;
    logic [6:0] a;
    reset = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    checkOutput();
    cyc(H);

    payload = '{8'h3C};
    applyStimulus(7'h50, 1'b0, 1, 1'b0);
    check("rx_hold_3c", rx_data, 8'h3C);

    payload = '{8'h96};
    applyStimulus(7'h50, 1'b1, 1, 1'b0);

    payload = '{8'h11, 8'h22, 8'h33};
    applyStimulus(7'h50, 1'b1, 3, 1'b0);

    applyStimulus(7'h51, 1'b0, 0, 1'b0);

    payload = '{8'h55};
    applyStimulus(7'h50, 1'b0, 1, 1'b1);
    payload = '{8'hC7};
    applyStimulus(7'h50, 1'b1, 1, 1'b0);
    check("rx_hold_55", rx_data, 8'h55);

    // STOP in the middle of a written byte must not strobe
    bus_start();
    write_byte({SLAVE, 1'b0}, s);
    check("part_ack", s, 1'b0);
    for (int i = 0; i < 4; i++) clock_bit(i[0], s);
    bus_stop();
    cyc(H);
    check("part_busy", busy, 1'b0);

    // Reset while the responder is holding SDA low for the address ack
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'hA1 >> i) & 8'h01) != 0, s);
    m_sda = 1'b1;
    cyc(H);
    check("ack_drive", sda_drv, 1'b0);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    checkOutput();
    m_scl = 1'b1; cyc(H);
    m_scl = 1'b0; cyc(2);
    bus_stop();
    cyc(H);

    for (int t = 0; t < 25; t++) begin
      int  n;
      bit  rep;
      if ($urandom_range(0, 3) != 0) a = SLAVE;
      else begin
        a = 7'($urandom_range(0, 127));
        if (a == SLAVE) a = a + 7'd1;
      end
      n   = $urandom_range(1, 3);
      rep = ($urandom_range(0, 2) == 0);
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(0, 255)));
      applyStimulus(a, 1'($urandom_range(0, 1)), n, rep);
    end
    bus_stop();
    cyc(H);
    check("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
